// File: rtl/arb4_decode_ctrl.sv
// ---------------------------------------------------------------------------
// arb4_decode_ctrl
//
// Four-requester round-robin arbiter for a single shared resource. One owner
// at a time. Priority rotates: the search starts one position after the last
// owner and wraps 3 -> 0. Every release is followed by at least one idle
// cycle before the next grant.
//
// Optional feature (compile-time macro ARB4_TIMEOUT_EN):
//   Builds a hold-time counter. An owner holding the grant for TIMEOUT
//   cycles without releasing is forced off. timeout pulses for that
//   release cycle. Without the macro no counter exists, timeout is tied
//   low, and ownership is unbounded.
//
// Parameters:
//   TIMEOUT  max cycles a requester may hold the grant (2..255), default 15
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  request per requester, bit i = requester i
//   done     in   1  owner releases the resource this cycle
//   grant_n  out  4  one-cold registered grant, 1111 = no owner
//   gnt_idx  out  2  registered index of current/last owner
//   busy     out  1  registered, high while an owner holds the grant
//   timeout  out  1  registered one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module arb4_decode_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant_n,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("arb4_decode_ctrl: TIMEOUT must be within 2..255");
  end

  state_t     state, state_nx;
  logic [3:0] grant_n_nx;
  logic [1:0] gnt_idx_nx;
  logic       busy_nx;
  logic [1:0] last, last_nx;

  logic [1:0] sel;
  logic       sel_vld;
  logic [1:0] cand;

  logic       rel_norm;
  logic       rel;

`ifdef ARB4_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  logic [7:0] cnt, cnt_nx;
  logic       expire;
  logic       timeout_nx;

  // cnt holds the number of completed owner cycles before the current one,
  // so reaching TLIM means this is the TIMEOUT-th held cycle.
  assign expire = (cnt == TLIM);
`endif

  // Round-robin search: last+1, last+2, last+3, then last itself.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    grant_n_nx = grant_n;
    gnt_idx_nx = gnt_idx;
    busy_nx    = busy;
    last_nx    = last;
    rel_norm   = done | ~req[gnt_idx];
`ifdef ARB4_TIMEOUT_EN
    cnt_nx     = cnt;
    timeout_nx = 1'b0;
    rel        = rel_norm | expire;
`else
    rel        = rel_norm;
`endif

    unique case (state)
      IDLE: begin
        grant_n_nx = '1;
        busy_nx    = 1'b0;
        if (sel_vld) begin
          state_nx   = OWN;
          grant_n_nx = ~(4'b0001 << sel);
          gnt_idx_nx = sel;
          busy_nx    = 1'b1;
`ifdef ARB4_TIMEOUT_EN
          cnt_nx     = '0;
`endif
        end
      end
      OWN: begin
        if (rel) begin
          state_nx   = IDLE;
          grant_n_nx = '1;
          busy_nx    = 1'b0;
          last_nx    = gnt_idx;
`ifdef ARB4_TIMEOUT_EN
          // A normal release coinciding with expiry is not reported as timeout.
          timeout_nx = ~rel_norm;
`endif
        end
`ifdef ARB4_TIMEOUT_EN
        else begin
          cnt_nx = cnt + 8'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_n <= '1;
      gnt_idx <= '0;
      busy    <= 1'b0;
      last    <= '1;
    end else begin
      state   <= state_nx;
      grant_n <= grant_n_nx;
      gnt_idx <= gnt_idx_nx;
      busy    <= busy_nx;
      last    <= last_nx;
    end
  end

`ifdef ARB4_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      timeout <= timeout_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arb4_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb4_decode_ctrl
//
// Scoreboard bench for arb4_decode_ctrl. Each applied cycle pushes the
// expected registered outputs {grant_n, gnt_idx, busy, timeout}; after the
// edge the scenario task pops and compares them, and also checks that
// grant_n is at most one-cold and busy tracks grant_n != 1111.
// ---------------------------------------------------------------------------
module tb_arb4_decode_ctrl;

`ifdef ARB4_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 15;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] grant_n;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  logic [7:0] sb [$];
  int vectors = 0;
  int miscompares = 0;

  arb4_decode_ctrl #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant_n (grant_n),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input logic [3:0] gn, input logic [1:0] ix,
                                    input logic b, input logic t);
    return {gn, ix, b, t};
  endfunction

  // Drive one cycle of inputs, record expectation, sample #1 after the edge.
  task automatic apply(input logic r, input logic [3:0] q, input logic d, input logic [7:0] e);
    rst  = r;
    req  = q;
    done = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, (k == 1) ? 4'hF : 4'h0, 1'b1, ex(4'hF, 2'd0, 1'b0, 1'b0));
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask

  // All four requesting, done on every third owner cycle: 0,1,2,3,0.
  task automatic test_rotation;
    logic [7:0] got, exp, e;
    logic [3:0] gn;
    int o;
    for (int k = 0; k < 5; k++) begin
      o  = k % 4;
      gn = ~(4'b0001 << o);
      for (int ph = 0; ph < 4; ph++) begin
        e = (ph == 3) ? ex(4'hF, 2'(o), 1'b0, 1'b0) : ex(gn, 2'(o), 1'b1, 1'b0);
        apply(1'b0, 4'hF, (ph == 3), e);
        got = {grant_n, gnt_idx, busy, timeout};
        exp = sb.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL rotation[%0d.%0d]: got %b want %b", k, ph, got, exp);
        end
        vectors++;
        if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
          miscompares++;
          $display("FAIL rotation_inv[%0d.%0d]: grant_n=%b busy=%b", k, ph, grant_n, busy);
        end
      end
    end
  endtask

  // Lone requester re-granted after its own release; gnt_idx holds in idle;
  // done in idle is ignored.
  task automatic test_regrant;
    logic [7:0] got, exp;
    logic [3:0] tq [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic       td [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] te [6];
    te[0] = ex(4'b1011, 2'd2, 1'b1, 1'b0);
    te[1] = ex(4'b1111, 2'd2, 1'b0, 1'b0);
    te[2] = ex(4'b1011, 2'd2, 1'b1, 1'b0);
    te[3] = ex(4'b1111, 2'd2, 1'b0, 1'b0);
    te[4] = ex(4'b1111, 2'd2, 1'b0, 1'b0);
    te[5] = ex(4'b1111, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, tq[k], td[k], te[k]);
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL regrant[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL regrant_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask

  // Owner 1; other req bits toggle (ignored); then req[1] drop with done.
  task automatic test_simul_release;
    logic [7:0] got, exp;
    logic [3:0] tq [6] = '{4'b0010, 4'b0010, 4'b1011, 4'b1001, 4'b1001, 4'b1001};
    logic       td [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] te [6];
    te[0] = ex(4'b1101, 2'd1, 1'b1, 1'b0);
    te[1] = ex(4'b1101, 2'd1, 1'b1, 1'b0);
    te[2] = ex(4'b1101, 2'd1, 1'b1, 1'b0);
    te[3] = ex(4'b1111, 2'd1, 1'b0, 1'b0);
    te[4] = ex(4'b0111, 2'd3, 1'b1, 1'b0);
    te[5] = ex(4'b0111, 2'd3, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, tq[k], td[k], te[k]);
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL simul_release[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL simul_release_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask

  // Reset while owner 3 holds; afterwards requester 0 wins over 3.
  task automatic test_reset_during_own;
    logic [7:0] got, exp;
    logic       tr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] tq [4] = '{4'b1001, 4'b1001, 4'b1001, 4'b0000};
    logic [7:0] te [4];
    te[0] = ex(4'b1111, 2'd0, 1'b0, 1'b0);
    te[1] = ex(4'b1110, 2'd0, 1'b1, 1'b0);
    te[2] = ex(4'b1110, 2'd0, 1'b1, 1'b0);
    te[3] = ex(4'b1111, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply(tr[k], tq[k], 1'b0, te[k]);
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_own[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_own_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask

`ifdef ARB4_TIMEOUT_EN
  // TIMEOUT=4: four held cycles, forced release with pulse, re-grant; then
  // done coinciding with expiry counts as a normal release.
  task automatic test_timeout;
    logic [7:0] got, exp, e;
    logic       d;
    logic [3:0] q;
    for (int k = 0; k < 11; k++) begin
      d = (k == 9);
      q = (k == 10) ? 4'b0000 : 4'b0001;
      if (k == 4)
        e = ex(4'hF, 2'd0, 1'b0, 1'b1);
      else if (k >= 9)
        e = ex(4'hF, 2'd0, 1'b0, 1'b0);
      else
        e = ex(4'b1110, 2'd0, 1'b1, 1'b0);
      apply(1'b0, q, d, e);
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask
`else
  // Without the hold limit a grant persists well past TIMEOUT cycles.
  task automatic test_unbounded_hold;
    logic [7:0] got, exp, e;
    for (int k = 0; k < 23; k++) begin
      e = (k == 22) ? ex(4'hF, 2'd0, 1'b0, 1'b0) : ex(4'b1110, 2'd0, 1'b1, 1'b0);
      apply(1'b0, (k == 22) ? 4'b0000 : 4'b0001, 1'b0, e);
      got = {grant_n, gnt_idx, busy, timeout};
      exp = sb.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL unbounded[%0d]: got %b want %b", k, got, exp);
      end
      vectors++;
      if ((($countones(~grant_n) <= 1) && (busy === (grant_n != 4'hF))) !== 1'b1) begin
        miscompares++;
        $display("FAIL unbounded_inv[%0d]: grant_n=%b busy=%b", k, grant_n, busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_rotation;
    test_regrant;
    test_simul_release;
    test_reset_during_own;
`ifdef ARB4_TIMEOUT_EN
    test_timeout;
`else
    test_unbounded_hold;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
